// File: rtl/mem_write_buffer.sv
// Write-back buffer between a direct-mapped cache and main memory: queues dirty blocks,
// forwards reads from the newest queued copy, and lets memory reads bypass queued writes.
module mem_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 27,
    parameter int unsigned DW    = 256
) (
    input  logic          clk,
    input  logic          proc_reset,
    input  logic          c_read,
    input  logic          c_write,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ready,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {C_IDLE, C_RDWAIT, C_ACK} c_state_e;
    typedef enum logic [1:0] {M_IDLE, M_WR, M_RD} m_state_e;

    c_state_e c_state_q, c_state_d;
    m_state_e m_state_q, m_state_d;

    logic [AW-1:0] fifo_addr_q [DEPTH];
    logic [DW-1:0] fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_pend_q, rd_pend_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;

    logic          push, pop, rd_pend_set, rd_pend_clr, full;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] scan_idx;

    assign full = (count_q == CW'(DEPTH));

    // Scan oldest to newest so the last valid match left standing is the newest entry.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + PW'(i);
            if ((32'(count_q) > i) && (fifo_addr_q[scan_idx] == c_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[scan_idx];
            end
        end
    end

    always_comb begin
        c_state_d   = c_state_q;
        push        = 1'b0;
        rd_pend_set = 1'b0;
        rd_addr_d   = rd_addr_q;
        c_rdata_d   = c_rdata_q;
        unique case (c_state_q)
            C_IDLE: begin
                if (c_write) begin
                    if (!full) begin
                        push      = 1'b1;
                        c_state_d = C_ACK;
                    end
                end else if (c_read) begin
                    if (fwd_hit) begin
                        c_rdata_d = fwd_data;
                        c_state_d = C_ACK;
                    end else begin
                        rd_addr_d   = c_addr;
                        rd_pend_set = 1'b1;
                        c_state_d   = C_RDWAIT;
                    end
                end
            end
            C_RDWAIT: begin
                if ((m_state_q == M_RD) && mem_ready) begin
                    c_rdata_d = mem_rdata;
                    c_state_d = C_ACK;
                end
            end
            C_ACK:   c_state_d = C_IDLE;
            default: c_state_d = C_IDLE;
        endcase
    end

    always_comb begin
        m_state_d   = m_state_q;
        pop         = 1'b0;
        rd_pend_clr = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        unique case (m_state_q)
            M_IDLE: begin
                if (rd_pend_q) begin
                    m_state_d = M_RD;
                end else if (count_q != '0) begin
                    m_state_d = M_WR;
                end
            end
            M_WR: begin
                mem_write = 1'b1;
                mem_addr  = fifo_addr_q[rd_ptr_q];
                mem_wdata = fifo_data_q[rd_ptr_q];
                if (mem_ready) begin
                    pop       = 1'b1;
                    m_state_d = M_IDLE;
                end
            end
            M_RD: begin
                mem_read = 1'b1;
                mem_addr = rd_addr_q;
                if (mem_ready) begin
                    rd_pend_clr = 1'b1;
                    m_state_d   = M_IDLE;
                end
            end
            default: m_state_d = M_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
        rd_pend_d = rd_pend_set | (rd_pend_q & ~rd_pend_clr);
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            c_state_q <= C_IDLE;
            m_state_q <= M_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            c_rdata_q <= '0;
        end else begin
            c_state_q <= c_state_d;
            m_state_q <= m_state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            c_rdata_q <= c_rdata_d;
        end
    end

    // Entry storage needs no reset: validity is carried entirely by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= c_addr;
            fifo_data_q[wr_ptr_q] <= c_wdata;
        end
    end

    assign c_ready = (c_state_q == C_ACK);
    assign c_rdata = c_rdata_q;

endmodule
